data_mem_ctrl: RTL

Parametrised single-port data memory for the 16-bit MIPS datapath, replacing the fixed 24-word array with a configurable width and depth, byte-enable writes, and a registered one-cycle read. It sits between the MEM pipeline stage and the storage array, exposing a valid/ready request port and a one-cycle response. A hardware clear sequencer zeroes the array word by word after reset or on command. No request is accepted while it runs.

---
 rtl/data_mem_pkg.sv | 30 +++
 rtl/data_mem_array.sv | 65 ++++++
 rtl/data_mem_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/data_mem_pkg.sv
// ---------------------------------------------------------------------------
// data_mem_pkg
// Shared definitions for the parametrised data memory controller:
//   - state_e        : controller FSM states (CLEAR sweep / READY for traffic)
//   - *_DEF          : default geometry for the 16-bit MIPS datapath
//   - be_width()     : byte-enable width for a given word width
//   - clr_cnt_width(): width of the clear-sweep counter / array index
// ---------------------------------------------------------------------------
package data_mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 256;
  localparam int ADDR_W_DEF = 16;

  // One enable bit per byte lane.
  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

  // Bits needed to index every word of the array.
  function automatic int clr_cnt_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// ---------------------------------------------------------------------------
// data_mem_array
// DATA_W x DEPTH storage with one byte-masked write port and one registered
// read port. The storage itself is never reset; only the read-data register
// is, so the response data has a defined value out of reset.
//
// Ports:
//   clk         : clock, all updates on rising edge
//   rst         : asynchronous active-high reset (read register only)
//   wr_en_i     : write strobe
//   wr_addr_i   : write word index
//   wr_data_i   : write data
//   wr_be_i     : per-byte write mask
//   rd_load_i   : load the read register this edge
//   rd_hit_i    : 1 = load mem[rd_addr_i], 0 = load zero
//   rd_addr_i   : read word index
//   rd_data_o   : registered read data (holds when rd_load_i = 0)
// ---------------------------------------------------------------------------
module data_mem_array
  import data_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  wr_en_i,
  input  logic [clr_cnt_width(DEPTH)-1:0]       wr_addr_i,
  input  logic [DATA_W-1:0]                     wr_data_i,
  input  logic [be_width(DATA_W)-1:0]           wr_be_i,
  input  logic                                  rd_load_i,
  input  logic                                  rd_hit_i,
  input  logic [clr_cnt_width(DEPTH)-1:0]       rd_addr_i,
  output logic [DATA_W-1:0]                     rd_data_o
);

  localparam int BE_W = be_width(DATA_W);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Byte-lane write; lanes with a cleared enable keep their old contents.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int i = 0; i < BE_W; i++) begin
        if (wr_be_i[i]) begin
          mem[wr_addr_i][8*i +: 8] <= wr_data_i[8*i +: 8];
        end
      end
    end
  end

  // Read samples the array before this edge's write lands, so a read and a
  // write to the same word on the same edge returns the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_load_i) begin
      rd_data_q <= rd_hit_i ? mem[rd_addr_i] : '0;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl
// Single-port data memory controller for the MEM stage. Accepts one
// valid/ready request per cycle and answers each accepted request with a
// one-cycle response on the following cycle. A clear sequencer zeroes the
// array word by word after reset or on clear_start; no requests are accepted
// while it runs.
//
// Ports:
//   clk, rst     : clock / asynchronous active-high reset
//   req_valid    : request present
//   req_ready    : request can be accepted this cycle (FSM in READY)
//   req_write    : 1 = write, 0 = read
//   req_addr     : word address (>= DEPTH is flagged as an error)
//   req_wdata    : write data
//   req_be       : byte enables for writes
//   clear_start  : start a clear sweep (sampled in READY only)
//   busy         : clear sweep in progress
//   rsp_valid    : response for the request accepted last cycle
//   rsp_rdata    : read data; 0 for writes and errors, held otherwise
//   rsp_err      : accepted address was out of range
// ---------------------------------------------------------------------------
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [DATA_W-1:0]             req_wdata,
  input  logic [be_width(DATA_W)-1:0]   req_be,
  input  logic                          clear_start,
  output logic                          busy,
  output logic                          rsp_valid,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic                          rsp_err
);

  localparam int                BE_W      = be_width(DATA_W);
  localparam int                CW        = clr_cnt_width(DEPTH);
  localparam logic [CW-1:0]     CLR_LAST  = CW'(DEPTH - 1);
  // One extra bit so DEPTH itself is representable even when it equals
  // 2**ADDR_W.
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  state_e          state_q, state_d;
  logic [CW-1:0]   clr_cnt_q, clr_cnt_d;
  logic            rsp_valid_q, rsp_err_q;

  logic            accept;
  logic            in_range;

  logic            wr_en;
  logic [CW-1:0]   wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [BE_W-1:0] wr_be;
  logic            rd_load;
  logic            rd_hit;
  logic [CW-1:0]   rd_addr;

  assign req_ready = (state_q == READY);
  assign busy      = (state_q == CLEAR);
  assign accept    = req_valid & req_ready;
  assign in_range  = ({1'b0, req_addr} < DEPTH_EXT);

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      CLEAR: begin
        // clear_start is deliberately ignored here: a held request must not
        // extend or restart a sweep that is already running.
        if (clr_cnt_q == CLR_LAST) begin
          state_d   = READY;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + CW'(1);
        end
      end
      READY: begin
        clr_cnt_d = '0;
        // A request accepted on this same edge still completes; the sweep
        // starts on the following cycle.
        if (clear_start) begin
          state_d = CLEAR;
        end
      end
      default: begin
        state_d   = CLEAR;
        clr_cnt_d = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Write-port mux: clear sequencer owns the port while sweeping
  // -------------------------------------------------------------------------
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    wr_be   = '0;
    if (state_q == CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = clr_cnt_q;
      wr_data = '0;
      wr_be   = '1;
    end else begin
      // Out-of-range writes are dropped rather than aliased onto low words.
      wr_en   = accept & req_write & in_range;
      wr_addr = req_addr[CW-1:0];
      wr_data = req_wdata;
      wr_be   = req_be;
    end
  end

  // Every accept reloads the read register: memory contents for an in-range
  // read, zero for writes and errors. Without an accept it holds.
  assign rd_load = accept;
  assign rd_hit  = accept & ~req_write & in_range;
  assign rd_addr = req_addr[CW-1:0];

  data_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .wr_be_i   (wr_be),
    .rd_load_i (rd_load),
    .rd_hit_i  (rd_hit),
    .rd_addr_i (rd_addr),
    .rd_data_o (rsp_rdata)
  );

  // -------------------------------------------------------------------------
  // Response registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= accept;
      rsp_err_q   <= accept & ~in_range;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;

endmodule
